// File: rtl/parc_mem_arb.sv
// Merges the core's imem and dmem request ports onto one memory port and steers
// the in-order memory responses back using a FIFO of 1-bit owner tags.
module parc_mem_arb #(
  parameter  int MAX_INFLIGHT = 4,
  // Message sizes for 32-bit address/data: {type, addr, len, data} and {type, len, data}
  localparam int REQ_W        = 67,
  localparam int RESP_W       = 35,
  localparam int PW           = $clog2(MAX_INFLIGHT),
  localparam int CW           = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  imemreq_msg,
  input  logic              imemreq_val,
  output logic              imemreq_rdy,
  output logic [RESP_W-1:0] imemresp_msg,
  output logic              imemresp_val,
  input  logic [REQ_W-1:0]  dmemreq_msg,
  input  logic              dmemreq_val,
  output logic              dmemreq_rdy,
  output logic [RESP_W-1:0] dmemresp_msg,
  output logic              dmemresp_val,
  output logic [REQ_W-1:0]  memreq_msg,
  output logic              memreq_val,
  input  logic              memreq_rdy,
  input  logic [RESP_W-1:0] memresp_msg,
  input  logic              memresp_val,
  output logic [CW-1:0]     inflight,
  output logic              err_orphan
);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_prio;
  logic          r_orphan;
  logic          r_tags [MAX_INFLIGHT];

  logic w_full;
  logic w_empty;
  logic w_grant_i;
  logic w_grant_d;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Full is taken from the registered count only, so a same-cycle pop never frees a slot
  assign w_full    = (r_count == CW'(MAX_INFLIGHT));
  assign w_empty   = (r_count == '0);
  assign w_grant_d = dmemreq_val & (~imemreq_val | r_prio);
  assign w_grant_i = imemreq_val & (~dmemreq_val | ~r_prio);

  assign memreq_val  = (imemreq_val | dmemreq_val) & ~w_full;
  assign memreq_msg  = w_grant_i ? imemreq_msg : dmemreq_msg;
  assign imemreq_rdy = w_grant_i & memreq_rdy & ~w_full;
  assign dmemreq_rdy = w_grant_d & memreq_rdy & ~w_full;

  assign w_push = imemreq_rdy | dmemreq_rdy;
  assign w_pop  = memresp_val & ~w_empty;
  assign w_head = r_tags[r_rptr];

  assign imemresp_val = w_pop & ~w_head;
  assign dmemresp_val = w_pop &  w_head;
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;

  assign inflight   = r_count;
  assign err_orphan = r_orphan;

  // Tag storage carries no reset; pointers and count define which entries are live
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wptr] <= dmemreq_rdy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_prio   <= 1'b1;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
        r_prio <= ~dmemreq_rdy;
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (memresp_val && w_empty) r_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parc_mem_arb.sv
// Directed bench for parc_mem_arb: reset, round-robin, full, steering, wrap, orphan.
module tb_parc_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [66:0] imemreq_msg, dmemreq_msg, memreq_msg;
  logic        imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic [34:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic        imemresp_val, dmemresp_val;
  logic        memreq_val, memreq_rdy, memresp_val;
  logic [2:0]  inflight;
  logic        err_orphan;

  int total = 0;
  int bad   = 0;

  parc_mem_arb #(.MAX_INFLIGHT(4)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] mkreq(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    return {rw, addr, 2'b00, data};
  endfunction

  function automatic logic [34:0] mkresp(input logic [31:0] data);
    return {1'b0, 2'b00, data};
  endfunction

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0]  wrap_port;
  logic [66:0] ia, da;

  initial begin
    ia = mkreq(1'b0, 32'h0000_1000, 32'h0);
    da = mkreq(1'b1, 32'h0000_2000, 32'h1234_5678);
    reset = 1'b0;
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0;
    imemreq_msg = ia; dmemreq_msg = da; memresp_msg = '0;
    tick(); tick();
    chk("rst_inflight", inflight, 3'd0);
    chk("rst_orphan", err_orphan, 1'b0);
    chk("rst_memreq_val", memreq_val, 1'b0);
    reset = 1'b1;

    // contention: d,i,d,i then full
    imemreq_val = 1'b1; dmemreq_val = 1'b1; memreq_rdy = 1'b1;
    #1;
    chk("rr0_drdy", dmemreq_rdy, 1'b1);
    chk("rr0_irdy", imemreq_rdy, 1'b0);
    chk("rr0_msg", memreq_msg, da);
    tick();
    chk("rr1_inflight", inflight, 3'd1);
    chk("rr1_irdy", imemreq_rdy, 1'b1);
    chk("rr1_drdy", dmemreq_rdy, 1'b0);
    chk("rr1_msg", memreq_msg, ia);
    tick();
    chk("rr2_drdy", dmemreq_rdy, 1'b1);
    chk("rr2_irdy", imemreq_rdy, 1'b0);
    tick();
    chk("rr3_irdy", imemreq_rdy, 1'b1);
    chk("rr3_drdy", dmemreq_rdy, 1'b0);
    tick();
    chk("full_inflight", inflight, 3'd4);
    chk("full_irdy", imemreq_rdy, 1'b0);
    chk("full_drdy", dmemreq_rdy, 1'b0);
    chk("full_memreq_val", memreq_val, 1'b0);

    // push/pop at full: pop only, head is dmem
    memresp_val = 1'b1; memresp_msg = mkresp(32'h0000_0D01);
    #1;
    chk("pp_irdy", imemreq_rdy, 1'b0);
    chk("pp_drdy", dmemreq_rdy, 1'b0);
    chk("pp_dval", dmemresp_val, 1'b1);
    chk("pp_ival", imemresp_val, 1'b0);
    chk("pp_dmsg", dmemresp_msg, mkresp(32'h0000_0D01));
    tick();
    memresp_val = 1'b0;
    #1;
    chk("pp_inflight", inflight, 3'd3);
    chk("pp_next_drdy", dmemreq_rdy, 1'b1);
    tick();
    chk("pp_refill", inflight, 3'd4);
    imemreq_val = 1'b0; dmemreq_val = 1'b0;

    // drain i,d,i,d
    for (int k = 0; k < 4; k++) begin
      memresp_val = 1'b1; memresp_msg = mkresp(32'(k));
      #1;
      chk("drain_ival", imemresp_val, logic'(k % 2 == 0));
      chk("drain_dval", dmemresp_val, logic'(k % 2 == 1));
      tick();
    end
    memresp_val = 1'b0;
    #1;
    chk("drain_inflight", inflight, 3'd0);
    chk("idle_msg_is_dmem", memreq_msg, da);

    // response steering
    imemreq_msg = mkreq(1'b0, 32'h100, 32'h0); imemreq_val = 1'b1;
    #1;
    chk("st_irdy", imemreq_rdy, 1'b1);
    chk("st_imsg", memreq_msg, mkreq(1'b0, 32'h100, 32'h0));
    tick();
    imemreq_val = 1'b0;
    dmemreq_msg = mkreq(1'b0, 32'h200, 32'h0); dmemreq_val = 1'b1;
    #1;
    chk("st_drdy", dmemreq_rdy, 1'b1);
    chk("st_dmsg", memreq_msg, mkreq(1'b0, 32'h200, 32'h0));
    tick();
    dmemreq_val = 1'b0;
    chk("st_inflight2", inflight, 3'd2);
    memresp_val = 1'b1; memresp_msg = mkresp(32'hAAAA);
    #1;
    chk("st_a_ival", imemresp_val, 1'b1);
    chk("st_a_dval", dmemresp_val, 1'b0);
    chk("st_a_msg", imemresp_msg, mkresp(32'hAAAA));
    tick();
    memresp_msg = mkresp(32'hBBBB);
    #1;
    chk("st_b_dval", dmemresp_val, 1'b1);
    chk("st_b_ival", imemresp_val, 1'b0);
    chk("st_b_msg", dmemresp_msg, mkresp(32'hBBBB));
    tick();
    memresp_val = 1'b0;
    #1;
    chk("st_inflight0", inflight, 3'd0);

    // wrap-around: 10 single-port requests, each answered the following cycle
    wrap_port = 10'b1100010110;
    for (int k = 0; k < 11; k++) begin
      imemreq_val = (k < 10) && !wrap_port[k];
      dmemreq_val = (k < 10) &&  wrap_port[k];
      memresp_val = (k > 0);
      #1;
      if (k < 10) chk("wr_rdy", wrap_port[k] ? dmemreq_rdy : imemreq_rdy, 1'b1);
      if (k > 0) begin
        chk("wr_ival", imemresp_val, !wrap_port[k-1]);
        chk("wr_dval", dmemresp_val,  wrap_port[k-1]);
      end
      tick();
    end
    imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b0;
    #1;
    chk("wr_inflight", inflight, 3'd0);

    // orphan after reset mid-operation
    dmemreq_val = 1'b1;
    tick(); tick();
    dmemreq_val = 1'b0;
    chk("or_inflight2", inflight, 3'd2);
    reset = 1'b0;
    #1;
    chk("or_async_clear", inflight, 3'd0);
    #1;
    reset = 1'b1;
    memresp_val = 1'b1; memresp_msg = mkresp(32'hDEAD);
    #1;
    chk("or1_ival", imemresp_val, 1'b0);
    chk("or1_dval", dmemresp_val, 1'b0);
    chk("or1_flag_pre", err_orphan, 1'b0);
    tick();
    chk("or1_flag", err_orphan, 1'b1);
    chk("or1_inflight", inflight, 3'd0);
    chk("or2_ival", imemresp_val, 1'b0);
    chk("or2_dval", dmemresp_val, 1'b0);
    tick();
    memresp_val = 1'b0;
    #1;
    chk("or2_inflight", inflight, 3'd0);
    chk("or2_flag", err_orphan, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parc_mem_arb.md
# parc_mem_arb

Two-port to one-port memory arbiter between the PARCv2 core and the shared test memory. It merges the core's instruction request port and data request port onto a single memory request port. It records which port owns each accepted request and steers the in-order memory responses back to the correct core response port. It sits directly downstream of the core's imem/dmem ports.

## Interface
Parameters:
- `MAX_INFLIGHT`, default 4: outstanding-request capacity (tag FIFO depth); a power of two, 2..16.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0); clears all state immediately.
- `imemreq_msg` in `VC_MEM_REQ_MSG_SZ(32,32)`: instruction request from the core.
- `imemreq_val` in 1, `imemreq_rdy` out 1: instruction request handshake.
- `imemresp_msg` out `VC_MEM_RESP_MSG_SZ(32)`, `imemresp_val` out 1: instruction response. There is no ready; the core always accepts.
- `dmemreq_msg` in `VC_MEM_REQ_MSG_SZ(32,32)`: data request from the core.
- `dmemreq_val` in 1, `dmemreq_rdy` out 1: data request handshake.
- `dmemresp_msg` out `VC_MEM_RESP_MSG_SZ(32)`, `dmemresp_val` out 1: data response. There is no ready.
- `memreq_msg` out `VC_MEM_REQ_MSG_SZ(32,32)`, `memreq_val` out 1, `memreq_rdy` in 1: merged request to memory.
- `memresp_msg` in `VC_MEM_RESP_MSG_SZ(32)`, `memresp_val` in 1: memory response. Memory returns responses strictly in request order.
- `inflight` out `$clog2(MAX_INFLIGHT)+1`: current count of outstanding requests.
- `err_orphan` out 1: sticky flag; set when a response arrives while nothing is outstanding.

## Operation
- A request transfers on any cycle where val and rdy are both 1 on the same port.
- `full` = (`inflight` == `MAX_INFLIGHT`). It is derived from the register value only; a same-cycle pop does not relieve `full`.
- `memreq_val` = (`imemreq_val` | `dmemreq_val`) & !`full`.
- Grant:
  - If only one port is valid, that port wins.
  - If both ports are valid, the port named by the 1-bit priority register `prio` wins (`prio`=1 means dmem).
- `memreq_msg` equals the winner's message bit-for-bit. When neither port is valid, it equals `dmemreq_msg`.
- `imemreq_rdy` = grant_i & `memreq_rdy` & !`full`. `dmemreq_rdy` = grant_d & `memreq_rdy` & !`full`. At most one of the two is 1 in any cycle.
- Priority update: on an accepted transfer, `prio` points to the other port. Otherwise `prio` holds. This gives round-robin under contention.
- Tag FIFO:
  - Circular buffer of `MAX_INFLIGHT` 1-bit entries (0 = imem, 1 = dmem), with read and write pointers of `$clog2(MAX_INFLIGHT)` bits.
  - Push on an accepted request. Pop on `memresp_val` when not empty.
  - Pointers wrap modulo `MAX_INFLIGHT`.
  - Push and pop in the same cycle leaves the count unchanged.
- Response steering:
  - `imemresp_val` = `memresp_val` & !empty & head==0.
  - `dmemresp_val` = `memresp_val` & !empty & head==1.
  - Both response message outputs are wired to `memresp_msg`.
- Orphan response: if `memresp_val`=1 while `inflight`==0, the response is dropped (neither resp_val asserts), no pop occurs, and `err_orphan` sets. The flag clears only on reset.
- Reset (asserted):
  - Outputs: `inflight`=0, `err_orphan`=0.
  - State: FIFO pointers = 0, `prio`=1 (dmem favoured).
  - Combinational outputs follow from this state.
- Reset mid-operation: all outstanding tags are discarded. Responses for pre-reset requests arriving afterwards are treated as orphans.

## Timing
- Request path is combinational, zero latency: `memreq_*` and `*req_rdy` respond in the same cycle as `*req_val` and `memreq_rdy`. The path from `memreq_rdy` to `*req_rdy` is also combinational.
- Response path is combinational, zero latency: `memresp_val` drives `*resp_val` in the same cycle.
- `inflight`, `prio`, the pointers, and `err_orphan` update on the clock edge following the event.
- Back-to-back transfers: one accepted request per cycle maximum, and one response per cycle.
- Full throughput when memory has 1-cycle latency requires `MAX_INFLIGHT` ≥ 2.

## Test plan
- **Reset values:** after reset release, `inflight`=0, `err_orphan`=0. With `imemreq_val`=`dmemreq_val`=1 and `memreq_rdy`=1, the first grant goes to dmem.
- **Contention round-robin:** both ports valid for 4 cycles with `memreq_rdy`=1 and memory holding responses. Required grant order d,i,d,i; `inflight` steps to 4 and then `full` blocks both ports (both rdy=0).
- **Response steering:** issue imem addr 0x100, then dmem addr 0x200. Return data 0xAAAA then 0xBBBB in consecutive cycles. Required: `imemresp_val` with 0xAAAA, then `dmemresp_val` with 0xBBBB; `inflight` returns to 0.
- **Simultaneous push/pop at full:** with `inflight`=4, `memresp_val`=1 and both reqs valid. Required: no request accepted that cycle, `inflight` becomes 3, and a request is accepted the next cycle.
- **Wrap-around:** 10 sequential single-port requests, each answered immediately, with `MAX_INFLIGHT`=4. Every response is routed to the issuing port and pointer wrap causes no misroute.
- **Orphan and reset mid-operation:** issue 2 dmem requests, pulse `reset` low, then deliver 2 responses. Required: no `*resp_val` asserts, `err_orphan`=1 after the first response, and `inflight` stays 0.
